// File: rtl/flow_key_extractor_pkg.sv
// Shared definitions for the flow key extractor and the downstream matcher:
// the I/O module header ctrl code, the flow key field layout, the FSM state
// encoding and a helper that packs the key fields into the key bus.
package flow_key_extractor_pkg;

    // Ctrl value tagging the I/O queue module header word
    localparam logic [7:0]  IO_QUEUE_STAGE_NUM = 8'hFF;

    // Ethertype announcing an 802.1Q tag
    localparam logic [15:0] ETHERTYPE_VLAN     = 16'h8100;

    // Key field widths
    localparam int KEY_SHORT_W  = 1;
    localparam int KEY_INPORT_W = 16;
    localparam int KEY_MAC_W    = 48;
    localparam int KEY_ETYPE_W  = 16;
    localparam int KEY_VLAN_W   = 12;
    localparam int KEY_TOTAL_W  = KEY_SHORT_W + KEY_INPORT_W + 2 * KEY_MAC_W
                                + KEY_ETYPE_W + KEY_VLAN_W;

    // Key field positions (LSB of each field)
    localparam int KEY_VLAN_POS   = 0;
    localparam int KEY_ETYPE_POS  = KEY_VLAN_POS   + KEY_VLAN_W;
    localparam int KEY_SMAC_POS   = KEY_ETYPE_POS  + KEY_ETYPE_W;
    localparam int KEY_DMAC_POS   = KEY_SMAC_POS   + KEY_MAC_W;
    localparam int KEY_INPORT_POS = KEY_DMAC_POS   + KEY_MAC_W;
    localparam int KEY_SHORT_POS  = KEY_INPORT_POS + KEY_INPORT_W;

    // Parser states
    typedef enum logic [1:0] {
        MOD_HDRS = 2'd0,
        WORD1    = 2'd1,
        WORD2    = 2'd2,
        WAIT_EOP = 2'd3
    } fke_state_e;

    // Pack individual fields into the key bus layout
    function automatic logic [KEY_TOTAL_W-1:0] build_key(
        input logic                    short_pkt,
        input logic [KEY_INPORT_W-1:0] in_port,
        input logic [KEY_MAC_W-1:0]    dmac,
        input logic [KEY_MAC_W-1:0]    smac,
        input logic [KEY_ETYPE_W-1:0]  etype,
        input logic [KEY_VLAN_W-1:0]   vlan_id
    );
        logic [KEY_TOTAL_W-1:0] key;
        key                                    = '0;
        key[KEY_SHORT_POS]                     = short_pkt;
        key[KEY_INPORT_POS +: KEY_INPORT_W]    = in_port;
        key[KEY_DMAC_POS   +: KEY_MAC_W]       = dmac;
        key[KEY_SMAC_POS   +: KEY_MAC_W]       = smac;
        key[KEY_ETYPE_POS  +: KEY_ETYPE_W]     = etype;
        key[KEY_VLAN_POS   +: KEY_VLAN_W]      = vlan_id;
        return key;
    endfunction

endpackage

// File: rtl/flow_key_extractor.sv
// Flow key extractor: forwards the 64-bit packet stream with one cycle of
// latency and, in parallel, parses input port, MACs, ethertype and VLAN ID
// into a flow key. Exactly one key_valid pulse is produced per packet, in the
// same cycle the key-completing word leaves on out_wr.
module flow_key_extractor
    import flow_key_extractor_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int KEY_WIDTH  = KEY_TOTAL_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic [KEY_WIDTH-1:0]  key_data,
    output logic                  key_valid,
    input  logic                  key_nearly_full
);

    // Passthrough registers
    logic [DATA_WIDTH-1:0]   out_data_r;
    logic [CTRL_WIDTH-1:0]   out_ctrl_r;
    logic                    out_wr_r;

    // Key output registers
    logic [KEY_WIDTH-1:0]    key_data_r;
    logic                    key_valid_r;

    // Parser state and per-packet shadow fields
    fke_state_e              state_r;
    logic [KEY_INPORT_W-1:0] in_port_r;
    logic [KEY_MAC_W-1:0]    dmac_r;
    logic [15:0]             smac_hi_r;
    logic [31:0]             smac_lo_r;
    logic [KEY_VLAN_W-1:0]   vlan_r;

    // Decoded views of the incoming word
    logic                    accept_s;
    logic                    eop_s;
    logic                    io_hdr_s;
    logic [KEY_ETYPE_W-1:0]  word1_etype_s;
    logic                    word1_is_vlan_s;
    logic [KEY_VLAN_W-1:0]   word1_vid_s;

    // A stalled matcher queue or downstream stalls the input immediately
    assign in_rdy          = out_rdy & ~key_nearly_full;
    assign accept_s        = in_wr & in_rdy;

    // Any nonzero ctrl after the header phase marks the last word of a packet
    assign eop_s           = (in_ctrl != {CTRL_WIDTH{1'b0}});
    assign io_hdr_s        = (in_ctrl == IO_QUEUE_STAGE_NUM);

    // Word1 fields; the VLAN ID is only meaningful behind an 802.1Q ethertype
    assign word1_etype_s   = in_data[31:16];
    assign word1_is_vlan_s = (word1_etype_s == ETHERTYPE_VLAN);
    assign word1_vid_s     = word1_is_vlan_s ? in_data[11:0] : {KEY_VLAN_W{1'b0}};

    // Passthrough: register every accepted word unchanged, flag it on out_wr
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_r <= {DATA_WIDTH{1'b0}};
            out_ctrl_r <= {CTRL_WIDTH{1'b0}};
            out_wr_r   <= 1'b0;
        end else begin
            out_wr_r <= accept_s;
            if (accept_s) begin
                out_data_r <= in_data;
                out_ctrl_r <= in_ctrl;
            end else begin
                out_data_r <= out_data_r;
                out_ctrl_r <= out_ctrl_r;
            end
        end
    end

    // Header parser FSM: accumulates shadow fields and fires one key per packet.
    // The shadow is cleared whenever a key is emitted so the next packet starts
    // from zero (e.g. in_port stays 0 when no I/O header precedes it).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= MOD_HDRS;
            in_port_r   <= {KEY_INPORT_W{1'b0}};
            dmac_r      <= {KEY_MAC_W{1'b0}};
            smac_hi_r   <= 16'h0000;
            smac_lo_r   <= 32'h0000_0000;
            vlan_r      <= {KEY_VLAN_W{1'b0}};
            key_data_r  <= {KEY_WIDTH{1'b0}};
            key_valid_r <= 1'b0;
        end else begin
            key_valid_r <= 1'b0;
            if (accept_s) begin
                case (state_r)
                    MOD_HDRS: begin
                        if (io_hdr_s) begin
                            in_port_r <= in_data[31:16];
                        end else if (!eop_s) begin
                            dmac_r    <= in_data[63:16];
                            smac_hi_r <= in_data[15:0];
                            state_r   <= WORD1;
                        end else begin
                            // Other module headers carry nothing for the key
                            state_r   <= MOD_HDRS;
                        end
                    end
                    WORD1: begin
                        if (eop_s || !word1_is_vlan_s) begin
                            // Key completes here: either untagged, or the packet
                            // ends in word1 and is flagged short
                            key_data_r  <= build_key(eop_s, in_port_r, dmac_r,
                                                     {smac_hi_r, in_data[63:32]},
                                                     word1_etype_s, word1_vid_s);
                            key_valid_r <= 1'b1;
                            in_port_r   <= {KEY_INPORT_W{1'b0}};
                            dmac_r      <= {KEY_MAC_W{1'b0}};
                            smac_hi_r   <= 16'h0000;
                            smac_lo_r   <= 32'h0000_0000;
                            vlan_r      <= {KEY_VLAN_W{1'b0}};
                            state_r     <= eop_s ? MOD_HDRS : WAIT_EOP;
                        end else begin
                            smac_lo_r   <= in_data[63:32];
                            vlan_r      <= in_data[11:0];
                            state_r     <= WORD2;
                        end
                    end
                    WORD2: begin
                        // Inner ethertype completes a tagged key; EOP here is short
                        key_data_r  <= build_key(eop_s, in_port_r, dmac_r,
                                                 {smac_hi_r, smac_lo_r},
                                                 in_data[63:48], vlan_r);
                        key_valid_r <= 1'b1;
                        in_port_r   <= {KEY_INPORT_W{1'b0}};
                        dmac_r      <= {KEY_MAC_W{1'b0}};
                        smac_hi_r   <= 16'h0000;
                        smac_lo_r   <= 32'h0000_0000;
                        vlan_r      <= {KEY_VLAN_W{1'b0}};
                        state_r     <= eop_s ? MOD_HDRS : WAIT_EOP;
                    end
                    WAIT_EOP: begin
                        if (eop_s) begin
                            state_r <= MOD_HDRS;
                        end else begin
                            state_r <= WAIT_EOP;
                        end
                    end
                    default: begin
                        state_r <= MOD_HDRS;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign out_data  = out_data_r;
    assign out_ctrl  = out_ctrl_r;
    assign out_wr    = out_wr_r;
    assign key_data  = key_data_r;
    assign key_valid = key_valid_r;

endmodule

// File: doc/flow_key_extractor.md
Name: flow_key_extractor

Overview:
- Sits directly upstream of the action processor, in parallel with the exact-match lookup.
- Passes the 64-bit packet stream (module headers + Ethernet frame) through with one cycle of latency.
- Parses the packet's input port, MACs, ethertype and VLAN ID into a flow key, and emits exactly one key_valid pulse per packet to the matcher.
- The matcher turns each key into one action_valid for the action processor, so key order equals packet order.

Parameters:
DATA_WIDTH, 64, stream data width; only 64 supported.
CTRL_WIDTH, DATA_WIDTH/8, stream ctrl width.
KEY_WIDTH, 141, key bus width; fixed layout below.

Ports:
clk  in  1  core clock.
reset_n  in  1  asynchronous, active-low reset.
in_data  in  64  packet word.
in_ctrl  in  8  0 = payload word, IO_QUEUE_STAGE_NUM = I/O module header, other nonzero after payload = EOP byte mask.
in_wr  in  1  word valid; honoured only while in_rdy=1.
in_rdy  out  1  combinational: out_rdy & ~key_nearly_full.
out_data  out  64  registered copy of in_data.
out_ctrl  out  8  registered copy of in_ctrl.
out_wr  out  1  registered (in_wr & in_rdy).
out_rdy  in  1  downstream can take a word.
key_data  out  141  flow key, held stable until the next key.
key_valid  out  1  one-cycle pulse, one per packet.
key_nearly_full  in  1  matcher key queue cannot take more keys; stalls input.

Behaviour:
- Reset (async assert, sync release): out_data=0, out_ctrl=0, out_wr=0, key_data=0, key_valid=0, state=MOD_HDRS.
- Reset asserted mid-packet: the partial key is discarded; the bench restarts on a packet boundary.
- Accept = in_wr & in_rdy. All state advances only on accept.
- Passthrough: out_* equals the accepted word one cycle later; out_wr=0 on cycles with no accept. Ctrl values are never altered.
- Key layout: [140] short flag, [139:124] in_port, [123:76] dmac, [75:28] smac, [27:12] ethertype, [11:0] vlan_id.
- Key accumulates in a shadow register that is cleared at the start of each packet.
- FSM states and transitions:
  - MOD_HDRS:
    - ctrl=IO_QUEUE_STAGE_NUM → in_port = data[31:16].
    - Any other nonzero ctrl → ignored.
    - ctrl=0 → this word is word0: dmac = data[63:16], smac[47:32] = data[15:0]; go to WORD1.
    - No I/O header seen → in_port = 0.
  - WORD1:
    - smac[31:0] = data[63:32]; ethertype = data[31:16].
    - Ethertype ≠ 0x8100 → key complete; go to WAIT_EOP.
    - Ethertype = 0x8100 → vlan_id = data[11:0]; go to WORD2.
  - WORD2: ethertype = data[63:48] (inner type); key complete; go to WAIT_EOP.
  - WAIT_EOP: on an accepted word with ctrl≠0 → go to MOD_HDRS.
- key_valid timing: the key is registered and key_valid pulses in the cycle after the completing word is accepted. This is the same cycle in which that word appears on out_wr.
- Short packet (EOP word accepted in WORD1 or WORD2 before the key is complete):
  - Emit the key with the missing fields zero and the short flag = 1.
  - Return to MOD_HDRS.
  - Still exactly one key per packet.
- EOP handling: an EOP word is any nonzero ctrl seen in WORD1, WORD2 or WAIT_EOP. In WORD1/WORD2 the fields in that same word are still parsed before the key is emitted.
- Back-to-back packets:
  - The EOP of packet N and the header of packet N+1 may arrive on consecutive cycles.
  - key_valid pulses are never merged; worst case is one key every 2 accepted words.
- Backpressure: key_nearly_full is sampled combinationally into in_rdy. The matcher guarantees at least 2 free slots when it deasserts, covering the in-flight key.
- Simultaneous out_rdy drop and a key completion: the key still fires for the already-accepted word.

Decomposition:
- Shared defines package:
  - IO_QUEUE_STAGE_NUM.
  - Key field widths and positions: KEY_SHORT_POS, KEY_INPORT_POS, KEY_DMAC_POS, KEY_SMAC_POS, KEY_ETYPE_POS, KEY_VLAN_POS.
  - ETHERTYPE_VLAN = 16'h8100.
  - The matcher uses the same positions.
- No sub-module: FSM plus passthrough register fits in one file of about 200 lines.

Test Plan:
- Untagged packet:
  - Stimulus: I/O hdr src_port=0x0004; dmac=00:11:22:33:44:55, smac=66:77:88:99:AA:BB, type 0x0800; 5 words total.
  - Response: one key with in_port=4, those MACs, ethertype 0x0800, vlan 0, short 0. key_valid is 1 cycle after word1 is accepted. out stream is identical with 1-cycle latency.
- VLAN packet:
  - Stimulus: word1[31:16]=0x8100, word1[11:0]=0x123, word2[63:48]=0x86DD.
  - Response: key ethertype=0x86DD, vlan=0x123, pulse 1 cycle after word2 is accepted.
- Short packet: EOP ctrl=0x80 on word1 → key with short=1, ethertype from word1, vlan=0; exactly one pulse.
- Back-to-back packets with no gap, and one packet with no I/O header → two pulses in order; second key has in_port=0.
- Backpressure:
  - Stimulus: toggle out_rdy and key_nearly_full randomly every cycle over 100 packets.
  - Response: no dropped or duplicated words; key count = packet count; key contents match the scoreboard.
- Reset mid-packet: assert reset_n=0 asynchronously during WORD1 → all outputs 0 immediately; the next full packet yields a correct key.
